// File: rtl/maint_scheduler.sv
// Periodic DRAM maintenance scheduler: refresh, ZQ calibration and periodic-read timers,
// pending-work counters and the maint_req/ack/done handshake. Define MAINT_PERIODIC_RD_EN for RD.
module maint_scheduler #(
   parameter int unsigned REF_INTERVAL = 1560,
   parameter int unsigned ZQ_INTERVAL  = 25600,
   parameter int unsigned RD_INTERVAL  = 2048,
   parameter int unsigned REF_POSTPONE = 8,
   parameter int unsigned MAX_PENDING  = 9,
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned PEND_W       = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_calib_complete,
   input  logic              aref_en,
   input  logic              aref_en_valid,
   input  logic              program_busy,
   output logic              maint_req,
   output logic [1:0]        maint_type,
   input  logic              maint_ack,
   input  logic              maint_done,
   output logic              per_ref_init,
   output logic              per_zq_init,
   output logic              per_rd_init,
   output logic [PEND_W-1:0] ref_pending,
   output logic              ref_overflow
);

   if (MAX_PENDING <= REF_POSTPONE || MAX_PENDING >= (1 << PEND_W) ||
       REF_INTERVAL == 0 || ZQ_INTERVAL == 0 || RD_INTERVAL == 0) begin : g_bad_params
      $error("maint_scheduler: invalid parameter set");
   end

   localparam logic [1:0]        TYPE_REF  = 2'd0;
   localparam logic [1:0]        TYPE_ZQ   = 2'd1;
   localparam logic [1:0]        TYPE_RD   = 2'd2;
   localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
   localparam logic [PEND_W-1:0] PEND_URG  = PEND_W'(REF_POSTPONE);
   localparam logic [CNT_W-1:0]  REF_LAST  = CNT_W'(REF_INTERVAL - 1);
   localparam logic [CNT_W-1:0]  ZQ_LAST   = CNT_W'(ZQ_INTERVAL - 1);

   typedef enum logic [1:0] {StIdle, StReq, StBusy} state_e;

   // Tick and grant in the same cycle cancel; the counter saturates at both ends.
   function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cur,
                                                   input logic inc, input logic dec);
      logic [PEND_W-1:0] nxt;
      nxt = cur;
      if (inc && !dec && cur != PEND_MAX) begin
         nxt = cur + PEND_W'(1);
      end else if (dec && !inc && cur != '0) begin
         nxt = cur - PEND_W'(1);
      end
      return nxt;
   endfunction

   state_e            state_q, state_d;
   logic              aref_en_r;
   logic [CNT_W-1:0]  ref_timer_q, ref_timer_d;
   logic [CNT_W-1:0]  zq_timer_q, zq_timer_d;
   logic [PEND_W-1:0] zq_pend_q;
   logic              ref_tick, zq_tick;
   logic              grant, ref_dec, zq_dec;
   logic              ref_elig, zq_elig, rd_elig;
   logic              req_d;
   logic [1:0]        type_d;

   assign ref_tick = init_calib_complete && aref_en_r && (ref_timer_q == REF_LAST);
   assign zq_tick  = init_calib_complete && (zq_timer_q == ZQ_LAST);
   assign grant    = (state_q == StReq) && maint_ack;
   assign ref_dec  = grant && (maint_type == TYPE_REF);
   assign zq_dec   = grant && (maint_type == TYPE_ZQ);

   assign ref_elig = (ref_pending >= PEND_URG) || ((ref_pending != '0) && !program_busy);
   assign zq_elig  = (zq_pend_q != '0) && !program_busy;

   always_comb begin
      ref_timer_d = ref_timer_q + CNT_W'(1);
      if (!init_calib_complete || !aref_en_r || ref_tick || aref_en_valid) begin
         ref_timer_d = '0;
      end
      zq_timer_d = zq_timer_q + CNT_W'(1);
      if (!init_calib_complete || zq_tick) begin
         zq_timer_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = maint_req;
      type_d  = maint_type;
      case (state_q)
         StIdle: begin
            if (ref_elig) begin
               type_d  = TYPE_REF;
               req_d   = 1'b1;
               state_d = StReq;
            end else if (zq_elig) begin
               type_d  = TYPE_ZQ;
               req_d   = 1'b1;
               state_d = StReq;
            end else if (rd_elig) begin
               type_d  = TYPE_RD;
               req_d   = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            if (maint_ack) begin
               req_d   = 1'b0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (maint_done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         aref_en_r    <= 1'b1;
         ref_timer_q  <= '0;
         zq_timer_q   <= '0;
         ref_pending  <= '0;
         zq_pend_q    <= '0;
         ref_overflow <= 1'b0;
         maint_req    <= 1'b0;
         maint_type   <= TYPE_REF;
         per_ref_init <= 1'b0;
         per_zq_init  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ref_timer_q  <= ref_timer_d;
         zq_timer_q   <= zq_timer_d;
         zq_pend_q    <= pend_next(zq_pend_q, zq_tick, zq_dec);
         maint_req    <= req_d;
         maint_type   <= type_d;
         per_ref_init <= ref_dec;
         per_zq_init  <= zq_dec;
         if (aref_en_valid) begin
            aref_en_r <= aref_en;
         end
         // Disabling refresh forgives the owed refreshes; a request already raised stays up.
         if (aref_en_valid && !aref_en) begin
            ref_pending <= '0;
         end else begin
            ref_pending <= pend_next(ref_pending, ref_tick, ref_dec);
         end
         if (ref_tick && (ref_pending == PEND_MAX) && !ref_dec) begin
            ref_overflow <= 1'b1;
         end
      end
   end

`ifdef MAINT_PERIODIC_RD_EN
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_INTERVAL - 1);

   logic [CNT_W-1:0]  rd_timer_q;
   logic [PEND_W-1:0] rd_pend_q;
   logic              rd_tick, rd_dec;

   assign rd_tick = init_calib_complete && (rd_timer_q == RD_LAST);
   assign rd_dec  = grant && (maint_type == TYPE_RD);
   assign rd_elig = (rd_pend_q != '0) && !program_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_timer_q  <= '0;
         rd_pend_q   <= '0;
         per_rd_init <= 1'b0;
      end else begin
         rd_timer_q  <= (!init_calib_complete || rd_tick) ? '0 : rd_timer_q + CNT_W'(1);
         rd_pend_q   <= pend_next(rd_pend_q, rd_tick, rd_dec);
         per_rd_init <= rd_dec;
      end
   end
`else
   assign rd_elig     = 1'b0;
   assign per_rd_init = 1'b0;
`endif

endmodule

// File: tb/tb_maint_scheduler.sv
// Self-checking bench for maint_scheduler: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the maintenance rules.
module tb_maint_scheduler;
   localparam int REF_I    = 16;
   localparam int ZQ_I     = 100;
   localparam int RD_I     = 24;
   localparam int POSTPONE = 8;
   localparam int MAXP     = 9;
`ifdef MAINT_PERIODIC_RD_EN
   localparam bit RD_ON = 1'b1;
`else
   localparam bit RD_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       init_calib_complete = 1'b0;
   logic       aref_en = 1'b1;
   logic       aref_en_valid = 1'b0;
   logic       program_busy = 1'b0;
   logic       maint_ack = 1'b0;
   logic       maint_done = 1'b0;
   logic       maint_req;
   logic [1:0] maint_type;
   logic       per_ref_init, per_zq_init, per_rd_init;
   logic [3:0] ref_pending;
   logic       ref_overflow;

   always #5 clk = ~clk;

   maint_scheduler #(
      .REF_INTERVAL(REF_I),
      .ZQ_INTERVAL (ZQ_I),
      .RD_INTERVAL (RD_I),
      .REF_POSTPONE(POSTPONE),
      .MAX_PENDING (MAXP),
      .CNT_W       (16),
      .PEND_W      (4)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .init_calib_complete(init_calib_complete),
      .aref_en            (aref_en),
      .aref_en_valid      (aref_en_valid),
      .program_busy       (program_busy),
      .maint_req          (maint_req),
      .maint_type         (maint_type),
      .maint_ack          (maint_ack),
      .maint_done         (maint_done),
      .per_ref_init       (per_ref_init),
      .per_zq_init        (per_zq_init),
      .per_rd_init        (per_rd_init),
      .ref_pending        (ref_pending),
      .ref_overflow       (ref_overflow)
   );

   int checks = 0;
   int errors = 0;

   // Model: enabled cycles since the last tick, work owed, and handshake phase.
   int ref_age, zq_age, rd_age, ref_p, zq_p, rd_p, m_type, req_age, busy_age;
   bit aref_on, ovf, m_req, m_busy, p_ref, p_zq, p_rd;

   // Responder settings.
   bit resp_on, noise;
   int ack_delay, done_delay;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int bump(input int p, input bit inc, input bit dec);
      if (inc && !dec) return (p < MAXP) ? p + 1 : p;
      if (dec && !inc) return (p > 0) ? p - 1 : 0;
      return p;
   endfunction

   task automatic model_reset();
      ref_age = 0; zq_age = 0; rd_age = 0;
      ref_p = 0; zq_p = 0; rd_p = 0;
      aref_on = 1'b1; ovf = 1'b0; m_req = 1'b0; m_busy = 1'b0; m_type = 0;
      p_ref = 1'b0; p_zq = 1'b0; p_rd = 1'b0; req_age = 0; busy_age = 0;
   endtask

   task automatic model_update();
      bit t_ref, t_zq, t_rd, grant;
      int pick;
      t_ref = 1'b0; t_zq = 1'b0; t_rd = 1'b0;
      pick = -1;
      if (!m_req && !m_busy) begin
         if (ref_p >= POSTPONE || (ref_p > 0 && !program_busy)) pick = 0;
         else if (zq_p > 0 && !program_busy) pick = 1;
         else if (RD_ON && rd_p > 0 && !program_busy) pick = 2;
      end
      grant = m_req && maint_ack;
      if (init_calib_complete) begin
         if (aref_on) begin
            ref_age++;
            if (ref_age == REF_I) begin t_ref = 1'b1; ref_age = 0; end
         end
         zq_age++;
         if (zq_age == ZQ_I) begin t_zq = 1'b1; zq_age = 0; end
         if (RD_ON) begin
            rd_age++;
            if (rd_age == RD_I) begin t_rd = 1'b1; rd_age = 0; end
         end
      end else begin
         ref_age = 0; zq_age = 0; rd_age = 0;
      end
      if (aref_en_valid) begin
         ref_age = 0;
         aref_on = aref_en;
      end
      if (t_ref && ref_p == MAXP && !(grant && m_type == 0)) ovf = 1'b1;
      ref_p = bump(ref_p, t_ref, grant && m_type == 0);
      if (aref_en_valid && !aref_en) ref_p = 0;
      zq_p = bump(zq_p, t_zq, grant && m_type == 1);
      rd_p = bump(rd_p, t_rd, grant && m_type == 2);
      p_ref = grant && m_type == 0;
      p_zq  = grant && m_type == 1;
      p_rd  = grant && m_type == 2;
      if (grant) begin
         m_req = 1'b0; m_busy = 1'b1; busy_age = 0;
      end else if (m_busy) begin
         if (maint_done) m_busy = 1'b0;
         else busy_age++;
      end else if (m_req) begin
         req_age++;
      end else if (pick >= 0) begin
         m_req = 1'b1; m_type = pick; req_age = 0;
      end
   endtask

   task automatic compare();
      check("maint_req", maint_req, m_req);
      if (m_req) check("maint_type", maint_type, m_type);
      check("per_ref_init", per_ref_init, p_ref);
      check("per_zq_init", per_zq_init, p_zq);
      check("per_rd_init", per_rd_init, p_rd);
      check("ref_pending", ref_pending, ref_p);
      check("ref_overflow", ref_overflow, ovf);
   endtask

   task automatic step();
      if (resp_on) begin
         maint_ack  = m_req && req_age >= ack_delay;
         maint_done = m_busy ? (busy_age >= done_delay) : (noise && $urandom_range(0, 7) == 0);
      end
      @(posedge clk);
      if (rst_n) model_update();
      @(negedge clk);
      compare();
      aref_en_valid = 1'b0;
      if (!resp_on) begin
         maint_ack  = 1'b0;
         maint_done = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      init_calib_complete = 1'b0;
      program_busy = 1'b0;
      maint_ack = 1'b0;
      maint_done = 1'b0;
      aref_en_valid = 1'b0;
      aref_en = 1'b1;
      resp_on = 1'b0;
      noise = 1'b0;
      model_reset();
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   initial begin
      int n, n2;
      model_reset();
      @(negedge clk);

      // Reset state
      do_reset();
      check("rst_req", maint_req, 0);
      check("rst_pending", ref_pending, 0);
      check("rst_overflow", ref_overflow, 0);
      check("rst_pulse", per_ref_init, 0);

      // Idle program, immediate ack, done four cycles later
      do_reset();
      resp_on = 1'b1; ack_delay = 0; done_delay = 4; init_calib_complete = 1'b1;
      n = 0; n2 = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (per_ref_init) n++;
         if (maint_req && maint_type != 2'd0) n2++;
         if (k == 17) check("t1_first_req", maint_req, 1);
         if (k == 18) check("t1_first_pulse", per_ref_init, 1);
      end
      check("t1_ref_pulses", n, 6);
      check("t1_non_ref_type", n2, 0);
      check("t1_pending_end", ref_pending, 0);

      // Busy program: refresh postponed until it becomes urgent
      do_reset();
      program_busy = 1'b1; init_calib_complete = 1'b1;
      n = 0;
      for (int k = 1; k <= 128; k++) begin
         step();
         if (maint_req) n++;
         if (k == 127) check("t2_pending7_pre", ref_pending, 7);
      end
      check("t2_no_early_req", n, 0);
      check("t2_pending8", ref_pending, 8);
      step();
      check("t2_urgent_req", maint_req, 1);
      check("t2_type_ref", maint_type, 0);
      maint_ack = 1'b1;
      step();
      check("t2_pulse", per_ref_init, 1);
      check("t2_pending7", ref_pending, 7);
      check("t2_req_dropped", maint_req, 0);

      // REF and ZQ owed together: REF first, held through a slow ack, then ZQ
      do_reset();
      resp_on = 1'b1; ack_delay = 5; done_delay = 1; init_calib_complete = 1'b1;
      repeat (90) step();
      program_busy = 1'b1;
      repeat (10) step();
      check("t3_ref_owed", ref_pending, 1);
      check("t3_idle", maint_req, 0);
      program_busy = 1'b0;
      step();
      check("t3_ref_req", maint_req, 1);
      check("t3_ref_type", maint_type, 0);
      n = 0;
      repeat (5) begin
         step();
         if (maint_req && maint_type == 2'd0) n++;
      end
      check("t3_ref_held", n, 5);
      step();
      check("t3_ref_pulse", per_ref_init, 1);
      check("t3_ref_cleared", ref_pending, 0);
      repeat (3) step();
      check("t3_zq_req", maint_req, 1);
      check("t3_zq_type", maint_type, 1);
      repeat (5) step();
      check("t3_zq_type_stable", maint_type, 1);
      step();
      check("t3_zq_pulse", per_zq_init, 1);

      // Saturation and sticky overflow with ack withheld
      do_reset();
      program_busy = 1'b1; init_calib_complete = 1'b1;
      repeat (159) step();
      check("t4_pending_sat", ref_pending, 9);
      check("t4_no_ovf_yet", ref_overflow, 0);
      check("t4_req_waiting", maint_req, 1);
      step();
      check("t4_ovf", ref_overflow, 1);
      check("t4_pending_hold", ref_pending, 9);
      maint_ack = 1'b1;
      step();
      check("t4_pulse", per_ref_init, 1);
      check("t4_pending8", ref_pending, 8);
      maint_done = 1'b1;
      step();
      repeat (20) step();
      check("t4_ovf_sticky", ref_overflow, 1);

      // Disable refresh with work owed, then re-enable
      do_reset();
      program_busy = 1'b1; init_calib_complete = 1'b1;
      repeat (48) step();
      check("t5_pending3", ref_pending, 3);
      aref_en = 1'b0; aref_en_valid = 1'b1;
      step();
      check("t5_cleared", ref_pending, 0);
      n = 0;
      repeat (100) begin
         step();
         if (ref_pending != 4'd0 || maint_req) n++;
      end
      check("t5_quiet", n, 0);
      aref_en = 1'b1; aref_en_valid = 1'b1;
      step();
      repeat (15) step();
      check("t5_no_tick_yet", ref_pending, 0);
      step();
      check("t5_first_tick", ref_pending, 1);

      // Reset while a request is outstanding
      do_reset();
      init_calib_complete = 1'b1;
      repeat (18) step();
      check("t6_req_up", maint_req, 1);
      rst_n = 1'b0;
      #1;
      check("t6_async_drop", maint_req, 0);
      model_reset();
      n = 0;
      repeat (3) begin
         maint_ack = 1'b1;
         step();
         if (per_ref_init || per_zq_init || per_rd_init) n++;
      end
      rst_n = 1'b1;
      step();
      if (per_ref_init || per_zq_init || per_rd_init) n++;
      check("t6_no_pulse", n, 0);
      check("t6_pending_zero", ref_pending, 0);

      // Randomized traffic
      do_reset();
      resp_on = 1'b1; noise = 1'b1; init_calib_complete = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (init_calib_complete) begin
            if ($urandom_range(0, 99) == 0) init_calib_complete = 1'b0;
         end else if ($urandom_range(0, 4) == 0) begin
            init_calib_complete = 1'b1;
         end
         if ($urandom_range(0, 19) == 0) program_busy = ~program_busy;
         if ($urandom_range(0, 49) == 0) begin
            aref_en_valid = 1'b1;
            aref_en = ($urandom_range(0, 3) != 0);
         end
         if (!m_req) ack_delay = $urandom_range(0, 6);
         if (!m_busy) done_delay = $urandom_range(0, 6);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
